pcie_irq_aggregator: RTL

PCIE_IRQ_AGGREGATOR -- requirements
Module: pcie_irq_aggregator

---
 rtl/pcie_irq_aggregator.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pcie_irq_aggregator.sv
// Edge-detected event channels coalesced into one round-robin PCIe interrupt
// request with hold-off. Define PCIE_IRQ_OVF_EN to build the sticky overflow flags.
module pcie_irq_aggregator #(
    parameter  int NCH         = 4,
    parameter  int HOLDOFF_W   = 16,
    parameter  int TAP_STRETCH = 8,
    localparam int NUM_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [NCH-1:0]       ev_i,
    input  logic [NCH-1:0]       mask_i,
    input  logic                 clr_valid_i,
    input  logic [NCH-1:0]       clr_mask_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    output logic                 irq_req_o,
    output logic [NUM_W-1:0]     irq_num_o,
    input  logic                 irq_ack_i,
    output logic [NCH-1:0]       pending_o,
    output logic [NCH-1:0]       inserv_o,
    output logic [NCH-1:0]       overflow_o,
    output logic                 irqflagtap_o
);

    localparam int TAP_W = $clog2(TAP_STRETCH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               r_state;
    logic [NCH-1:0]       r_ev_d;
    logic                 r_armed;
    logic [NCH-1:0]       r_pending;
    logic [NCH-1:0]       r_inserv;
    logic                 r_req;
    logic [NUM_W-1:0]     r_num;
    logic [NUM_W-1:0]     r_last_grant;
    logic [HOLDOFF_W-1:0] r_hold_cnt;
    logic [TAP_W-1:0]     r_tap_cnt;

    logic [NCH-1:0]       w_rise;
    logic [NCH-1:0]       w_clr;
    logic [NCH-1:0]       w_reqable;
    logic [NCH-1:0]       w_rot;
    logic [NCH-1:0]       w_ack_set;
    logic                 w_ack;
    logic [NUM_W-1:0]     w_base;
    logic [NUM_W-1:0]     w_idx [NCH];
    logic                 w_grant_vld;
    logic [NUM_W-1:0]     w_grant;

    // The first cycle after reset only primes the edge register, so a line
    // already high when reset releases is not mistaken for a new event.
    assign w_rise    = r_armed ? (ev_i & ~r_ev_d) : '0;
    assign w_clr     = clr_valid_i ? clr_mask_i : '0;
    assign w_ack     = (r_state == S_REQ) && irq_ack_i;
    assign w_reqable = r_pending & ~mask_i & ~r_inserv;
    assign w_base    = (r_last_grant == NUM_W'(NCH - 1)) ? '0 : r_last_grant + NUM_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic [NUM_W:0] w_sum;
            assign w_sum         = {1'b0, w_base} + (NUM_W + 1)'(gi);
            assign w_idx[gi]     = (w_sum >= (NUM_W + 1)'(NCH)) ?
                                   NUM_W'(w_sum - (NUM_W + 1)'(NCH)) : w_sum[NUM_W-1:0];
            assign w_rot[gi]     = w_reqable[w_idx[gi]];
            assign w_ack_set[gi] = w_ack && (r_num == NUM_W'(gi));
        end
    endgenerate

    // Lowest rotated position wins, i.e. the first requester after last_grant.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx[i];
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_ev_d    <= '0;
            r_armed   <= 1'b0;
            r_pending <= '0;
            r_inserv  <= '0;
        end else begin
            r_ev_d    <= ev_i;
            r_armed   <= 1'b1;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_inserv  <= (r_inserv & ~w_clr) | w_ack_set;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_num        <= '0;
            r_last_grant <= NUM_W'(NCH - 1);
            r_hold_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_num   <= w_grant;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (irq_ack_i) begin
                        r_req        <= 1'b0;
                        r_last_grant <= r_num;
                        if (holdoff_i == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_hold_cnt <= holdoff_i;
                            r_state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt <= HOLDOFF_W'(1)) begin
                        r_hold_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLDOFF_W'(1);
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_tap_cnt <= '0;
        end else if (w_ack) begin
            r_tap_cnt <= TAP_W'(TAP_STRETCH);
        end else if (r_tap_cnt != '0) begin
            r_tap_cnt <= r_tap_cnt - TAP_W'(1);
        end
    end

`ifdef PCIE_IRQ_OVF_EN
    logic [NCH-1:0] r_overflow;

    // A clear in the same cycle as the lost event wins.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= (r_overflow & ~w_clr) | (w_rise & r_pending & ~w_clr);
        end
    end

    assign overflow_o = r_overflow;
`else
    assign overflow_o = '0;
`endif

    assign irq_req_o    = r_req;
    assign irq_num_o    = r_num;
    assign pending_o    = r_pending;
    assign inserv_o     = r_inserv;
    assign irqflagtap_o = (r_tap_cnt != '0);

endmodule
